move_capture_fsm: RTL
=====================

Name: move_capture_fsm

Overview:
- Sits directly downstream of the 64-input square arbiter. The arbiter reduces per-square board requests to one 6-bit square index.
- This block turns that index stream into a committed move (from-square, to-square).
- Each square is accepted only after it has been stable for a set number of cycles. Each phase has a timeout.
- The finished move is handed to the board-update stage over a valid/ready handshake.

Parameters:
- SQ_W, 6, square index width (64 squares).
- STABLE_CYC, 4, consecutive identical valid samples needed to accept a square (≥2).
- TIMEOUT_CYC, 1024, maximum cycles per capture phase before abort (> STABLE_CYC).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  single-cycle request to begin capturing a move; ignored unless busy=0.
- arb_sq  in  SQ_W  selected square index from the arbiter.
- arb_valid  in  1  arbiter has an active request this cycle.
- mv_valid  out  1  committed move available.
- mv_from  out  SQ_W  source square.
- mv_to  out  SQ_W  destination square.
- mv_ready  in  1  downstream accepts the move.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle abort pulse.
- err_code  out  2  01 = SRC timeout, 10 = DST timeout; holds its value until the next err pulse.

Behaviour:
- Reset (on a clk edge with rst=1): state=IDLE; all outputs 0; internal counters and last_sq cleared. Applies from any state, including ISSUE; mv_valid drops on that edge.
- States: IDLE, SRC, DST, ISSUE.
  - IDLE→SRC when start=1. arb inputs in the start cycle are not sampled; sampling begins the next cycle.
  - SRC→DST on acceptance: latch mv_from.
  - DST→ISSUE on acceptance: latch mv_to.
  - ISSUE→IDLE when mv_valid and mv_ready are both high at an edge.
  - start is ignored outside IDLE.
- Stability filter (in SRC and DST only), with stab_cnt, last_sq:
  - arb_valid=0 → stab_cnt=0.
  - Otherwise, if stab_cnt==0 or arb_sq!=last_sq → last_sq=arb_sq, stab_cnt=1.
  - Otherwise → stab_cnt+1.
  - Acceptance occurs in the cycle where arb_valid=1, arb_sq==last_sq and stab_cnt==STABLE_CYC-1, i.e. the STABLE_CYC-th identical sample. The state changes on that edge.
  - Latency: a square held from cycle k is latched at the end of cycle k+STABLE_CYC-1.
  - In DST, a sample with arb_sq==mv_from is treated as arb_valid=0. Null moves are therefore impossible; a lifted piece that is put back simply stalls until timeout.
  - Filter counters clear on every phase entry.
- Timeout: phase_cnt clears on SRC/DST entry and increments each cycle in the phase.
  - If phase_cnt==TIMEOUT_CYC-1 and there is no acceptance that cycle: err=1 for one cycle, err_code is set, state→IDLE, mv_from/mv_to cleared.
  - Acceptance and timeout in the same cycle: acceptance wins.
  - Counter width is $clog2(TIMEOUT_CYC); no wrap-around is possible.
- ISSUE:
  - mv_valid=1; mv_from and mv_to are held stable while mv_ready=0.
  - mv_valid goes low on the transfer edge.
  - start asserted in the transfer cycle is ignored. A new capture needs a start while IDLE.
- mv_from and mv_to keep their values after transfer until the next latch, timeout or reset.
- Arithmetic is unsigned. Square equality is full SQ_W-bit compare.

Decomposition:
- Shared package chess_pkg holds:
  - SQ_W;
  - the state encoding (IDLE=0, SRC=1, DST=2, ISSUE=3);
  - error code constants ERR_NONE, ERR_SRC_TO, ERR_DST_TO.
- One natural sub-module, sq_stable_filter, owns stab_cnt/last_sq.
  - Inputs: clk, rst, clear, sq, valid, exclude_en, exclude_sq.
  - Output: accept (plus sq_out).
  - It is instantiated once and reused across SRC and DST via clear.

Test Plan (STABLE_CYC=4, TIMEOUT_CYC=16 in bench):
1. Basic move: start; arb_sq=12 valid 4 cycles; arb_sq=28 valid 4 cycles; mv_ready=1 → mv_valid for 1 cycle, mv_from=12, mv_to=28, busy low the next cycle.
2. Glitch rejection: in SRC, sq=12 for 3 cycles then sq=13 for 4 cycles → mv_from=13, with acceptance on the 4th cycle of 13.
3. Source exclusion: in DST, hold sq=12 (the from-square) for 10 cycles, then sq=20 for 4 → mv_to=20, no err.
4. Timeout: start, arb_valid=0 for 16 cycles → err pulses once on cycle 16, err_code=01, busy=0. Repeat in DST → err_code=10.
5. Backpressure: reach ISSUE with mv_ready=0 for 5 cycles → mv_valid/from/to held constant; then mv_ready=1 → single transfer. start during ISSUE is ignored.
6. Reset mid-DST: rst=1 for 1 cycle → all outputs 0, state IDLE. Later arb activity without start produces no response.

Source files
------------

// File: rtl/chess_pkg.sv
// chess_pkg: shared square width, capture FSM state encoding and abort codes
package chess_pkg;
   localparam int SQ_W = 6;
   typedef enum logic [1:0] {IDLE = 2'd0, SRC = 2'd1, DST = 2'd2, ISSUE = 2'd3} state_t;
   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_SRC_TO = 2'b01;
   localparam logic [1:0] ERR_DST_TO = 2'b10;
endpackage

// File: rtl/sq_stable_filter.sv
// sq_stable_filter: accepts a square once seen on STABLE_CYC consecutive valid samples
// ports: clk, rst, clear (restart filtering), sq/valid (arbiter sample),
//        exclude_en/exclude_sq (square treated as no request), accept, sq_out (filtered square)
module sq_stable_filter
   import chess_pkg::*;
#(
   parameter int STABLE_CYC = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic [SQ_W-1:0] sq,
   input  logic            valid,
   input  logic            exclude_en,
   input  logic [SQ_W-1:0] exclude_sq,
   output logic            accept,
   output logic [SQ_W-1:0] sq_out
);
   localparam int CW = $clog2(STABLE_CYC + 1);
   logic [CW-1:0]   stab_cnt;
   logic [SQ_W-1:0] last_sq;
   logic            v, same;
   assign v      = valid && !(exclude_en && sq == exclude_sq);
   assign same   = stab_cnt != '0 && sq == last_sq;
   assign accept = v && same && stab_cnt == CW'(STABLE_CYC - 1);
   assign sq_out = last_sq;
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         stab_cnt <= '0;
         last_sq  <= '0;
      end else if (!v) stab_cnt <= '0;
      else if (!same) begin
         last_sq  <= sq;
         stab_cnt <= CW'(1);
      end else stab_cnt <= stab_cnt + 1'b1;
   end
endmodule

// File: rtl/move_capture_fsm.sv
// move_capture_fsm: turns the arbiter's square stream into a committed (from, to) move
// ports: clk, rst, start (begin capture when idle), arb_sq/arb_valid (arbiter output),
//        mv_valid/mv_from/mv_to/mv_ready (move handshake), busy, err (abort pulse), err_code
module move_capture_fsm
   import chess_pkg::*;
#(
   parameter int STABLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [SQ_W-1:0] arb_sq,
   input  logic            arb_valid,
   output logic            mv_valid,
   output logic [SQ_W-1:0] mv_from,
   output logic [SQ_W-1:0] mv_to,
   input  logic            mv_ready,
   output logic            busy,
   output logic            err,
   output logic [1:0]      err_code
);
   localparam int PW = $clog2(TIMEOUT_CYC);
   state_t          state;
   logic [PW-1:0]   phase_cnt;
   logic            sampling, accept, timeout;
   logic [SQ_W-1:0] sq_out;
   assign sampling = state == SRC || state == DST;
   assign timeout  = sampling && !accept && phase_cnt == PW'(TIMEOUT_CYC - 1);
   assign mv_valid = state == ISSUE;
   assign busy     = state != IDLE;
   // the filter restarts on every edge that does not continue an ongoing phase,
   // so it is empty on the first sample of SRC and of DST
   sq_stable_filter #(.STABLE_CYC(STABLE_CYC)) u_filt (
      .clk        (clk),
      .rst        (rst),
      .clear      (!sampling || accept || timeout),
      .sq         (arb_sq),
      .valid      (arb_valid),
      .exclude_en (state == DST),
      .exclude_sq (mv_from),
      .accept     (accept),
      .sq_out     (sq_out)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         phase_cnt <= '0;
         mv_from   <= '0;
         mv_to     <= '0;
         err       <= 1'b0;
         err_code  <= ERR_NONE;
      end else begin
         err       <= timeout;
         phase_cnt <= (sampling && !accept && !timeout) ? phase_cnt + 1'b1 : '0;
         if (timeout) begin
            state    <= IDLE;
            mv_from  <= '0;
            mv_to    <= '0;
            err_code <= state == SRC ? ERR_SRC_TO : ERR_DST_TO;
         end else begin
            case (state)
               IDLE:  if (start) state <= SRC;
               SRC:   if (accept) begin
                  mv_from <= sq_out;
                  state   <= DST;
               end
               DST:   if (accept) begin
                  mv_to <= sq_out;
                  state <= ISSUE;
               end
               ISSUE: if (mv_ready) state <= IDLE;
            endcase
         end
      end
   end
endmodule
